// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter family.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   presc_width()        : register width for a prescaler of a given ratio
package updown_mod_counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Width of a 0..presc-1 counter, never narrower than one bit.
  function automatic int unsigned presc_width(input int unsigned presc);
    return (presc <= 1) ? 1 : $clog2(presc);
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of updown_mod_counter.
//   master : drives en, up_dn, clr, load, load_val, ovf_clr; observes cnt_o, tc_o, ovf_o
//   slave  : the counter side of the same signals
interface updown_mod_counter_if #(
  parameter int unsigned DWIDTH = 7
);
  logic              en;
  logic              up_dn;
  logic              clr;
  logic              load;
  logic [DWIDTH-1:0] load_val;
  logic              ovf_clr;
  logic [DWIDTH-1:0] cnt_o;
  logic              tc_o;
  logic              ovf_o;

  modport master (
    output en, up_dn, clr, load, load_val, ovf_clr,
    input  cnt_o, tc_o, ovf_o
  );

  modport slave (
    input  en, up_dn, clr, load, load_val, ovf_clr,
    output cnt_o, tc_o, ovf_o
  );
endinterface

// File: rtl/updown_mod_counter_presc.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : advances the phase; low freezes it
//   sync_clr  : synchronous return to phase 0
//   tick_o    : en on the last phase (combinational)
// With PRESCALE = 1 no register exists and tick_o follows en.
module tick_prescaler
  import updown_mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick_o
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused;
      assign unused = ^{clk, rst, sync_clr};
      assign tick_o = en;
    end else begin : g_presc
      localparam int unsigned PW = presc_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] presc;

      assign tick_o = en & (presc == LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          presc <= '0;
        end else if (sync_clr || tick_o) begin
          presc <= '0;
        end else if (en) begin
          presc <= presc + PW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with prescaled enable, clear/load,
// wrap or saturate at the boundary, cascade carry and sticky overflow.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of updown_mod_counter_if
//              en/up_dn/clr/load/load_val/ovf_clr in; cnt_o/tc_o/ovf_o out
// Priority: clr > load > step. tc_o is combinational and feeds the en of a
// following stage; ovf_o latches any boundary step until clr/ovf_clr.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int unsigned DWIDTH   = 7,
  parameter int unsigned MODULUS  = 100,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input logic                 clk,
  input logic                 rst,
  updown_mod_counter_if.slave bus
);

  localparam logic [DWIDTH-1:0] CNT_MAX = DWIDTH'(MODULUS - 1);

  logic              tick;
  logic              presc_clr;
  logic              boundary;
  logic              tc;
  logic              ovf;
  logic [DWIDTH-1:0] cnt;
  logic [DWIDTH-1:0] cnt_step;
  logic [DWIDTH-1:0] load_eff;

  assign presc_clr = bus.clr | bus.load;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .sync_clr(presc_clr),
    .tick_o  (tick)
  );

  always_comb begin
    boundary = bus.up_dn ? (cnt == CNT_MAX) : (cnt == '0);
    load_eff = (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;
    if (boundary) begin
      if (SATURATE == MODE_SAT) cnt_step = cnt;
      else                      cnt_step = bus.up_dn ? '0 : CNT_MAX;
    end else begin
      cnt_step = bus.up_dn ? cnt + DWIDTH'(1) : cnt - DWIDTH'(1);
    end
    // rst gate keeps the carry quiet while the register is held in reset.
    tc = tick & ~bus.clr & ~bus.load & boundary & ~rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (bus.clr)       cnt <= '0;
      else if (bus.load) cnt <= load_eff;
      else if (tick)     cnt <= cnt_step;

      // Set beats ovf_clr so a simultaneous boundary event is not lost.
      if (bus.clr)          ovf <= 1'b0;
      else if (tc)          ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
    end
  end

  assign bus.cnt_o = cnt;
  assign bus.tc_o  = tc;
  assign bus.ovf_o = ovf;

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-DUT stimulus and observation: 0 wrap/M100, 1 sat/M100, 2 presc4/M100, 3 wrap/M8 (3 bits)
  logic       en_v   [4];
  logic       up_v   [4];
  logic       clr_v  [4];
  logic       ld_v   [4];
  logic [6:0] lv_v   [4];
  logic       oc_v   [4];
  logic [6:0] cnt_v  [4];
  logic       tc_v   [4];
  logic       ovf_v  [4];

  updown_mod_counter_if #(.DWIDTH(7)) if_a ();
  updown_mod_counter_if #(.DWIDTH(7)) if_s ();
  updown_mod_counter_if #(.DWIDTH(7)) if_p ();
  updown_mod_counter_if #(.DWIDTH(3)) if_b ();

  updown_mod_counter #(.DWIDTH(7), .MODULUS(100), .PRESCALE(1), .SATURATE(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  updown_mod_counter #(.DWIDTH(7), .MODULUS(100), .PRESCALE(1), .SATURATE(1))
    dut_s (.clk(clk), .rst(rst), .bus(if_s));
  updown_mod_counter #(.DWIDTH(7), .MODULUS(100), .PRESCALE(4), .SATURATE(0))
    dut_p (.clk(clk), .rst(rst), .bus(if_p));
  updown_mod_counter #(.DWIDTH(3), .MODULUS(8), .PRESCALE(1), .SATURATE(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  assign if_a.en = en_v[0]; assign if_a.up_dn = up_v[0]; assign if_a.clr = clr_v[0];
  assign if_a.load = ld_v[0]; assign if_a.load_val = lv_v[0]; assign if_a.ovf_clr = oc_v[0];
  assign cnt_v[0] = if_a.cnt_o; assign tc_v[0] = if_a.tc_o; assign ovf_v[0] = if_a.ovf_o;

  assign if_s.en = en_v[1]; assign if_s.up_dn = up_v[1]; assign if_s.clr = clr_v[1];
  assign if_s.load = ld_v[1]; assign if_s.load_val = lv_v[1]; assign if_s.ovf_clr = oc_v[1];
  assign cnt_v[1] = if_s.cnt_o; assign tc_v[1] = if_s.tc_o; assign ovf_v[1] = if_s.ovf_o;

  assign if_p.en = en_v[2]; assign if_p.up_dn = up_v[2]; assign if_p.clr = clr_v[2];
  assign if_p.load = ld_v[2]; assign if_p.load_val = lv_v[2]; assign if_p.ovf_clr = oc_v[2];
  assign cnt_v[2] = if_p.cnt_o; assign tc_v[2] = if_p.tc_o; assign ovf_v[2] = if_p.ovf_o;

  assign if_b.en = en_v[3]; assign if_b.up_dn = up_v[3]; assign if_b.clr = clr_v[3];
  assign if_b.load = ld_v[3]; assign if_b.load_val = lv_v[3][2:0]; assign if_b.ovf_clr = oc_v[3];
  assign cnt_v[3] = {4'b0000, if_b.cnt_o}; assign tc_v[3] = if_b.tc_o; assign ovf_v[3] = if_b.ovf_o;

  typedef struct {
    int unsigned sel;
    string       name;
    logic        en, up, clr, ld;
    logic [6:0]  lv;
    logic        oc;
    logic        tc;
    logic [6:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t exp_q [$];
  vec_t tbl   [$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic vec_t mk(input int unsigned sel, input string name,
                              input logic en, input logic up, input logic clr,
                              input logic ld, input logic [6:0] lv, input logic oc,
                              input logic tc, input logic [6:0] cnt, input logic ovf);
    vec_t v;
    v.sel = sel; v.name = name; v.en = en; v.up = up; v.clr = clr; v.ld = ld;
    v.lv = lv; v.oc = oc; v.tc = tc; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      en_v[i] = 1'b0; up_v[i] = 1'b0; clr_v[i] = 1'b0;
      ld_v[i] = 1'b0; lv_v[i] = '0;   oc_v[i]  = 1'b0;
    end
  endtask

  // Drive one cycle at posedge+1, sample tc before the edge, compare after it.
  task automatic run(input vec_t v);
    vec_t e;
    logic tc_s;
    idle_all();
    en_v[v.sel] = v.en; up_v[v.sel] = v.up; clr_v[v.sel] = v.clr;
    ld_v[v.sel] = v.ld; lv_v[v.sel] = v.lv; oc_v[v.sel] = v.oc;
    exp_q.push_back(v);
    #2;
    tc_s = tc_v[v.sel];
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, ".tc"},  32'(tc_s),         32'(e.tc));
      chk({e.name, ".cnt"}, 32'(cnt_v[e.sel]), 32'(e.cnt));
      chk({e.name, ".ovf"}, 32'(ovf_v[e.sel]), 32'(e.ovf));
    end
  endtask

  initial begin
    idle_all();
    // Down-count enable at 0 during reset: tc must stay low while rst is high.
    en_v[0] = 1'b1;
    #12;
    chk("rst.tc_a", 32'(tc_v[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst.cnt%0d", i), 32'(cnt_v[i]), 32'd0);
      chk($sformatf("rst.ovf%0d", i), 32'(ovf_v[i]), 32'd0);
    end
    en_v[0] = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Up count 0 -> 99, wrap with tc, then on to 42.
    for (int i = 0; i < 99; i++)
      run(mk(0, $sformatf("up%0d", i + 1), 1, 1, 0, 0, 0, 0, 0, 7'(i + 1), 0));
    run(mk(0, "upwrap", 1, 1, 0, 0, 0, 0, 1, 0, 1));
    for (int i = 1; i <= 42; i++)
      run(mk(0, $sformatf("up2_%0d", i), 1, 1, 0, 0, 0, 0, 0, 7'(i), 1));

    // Two enabled cycles into the prescale-4 stage before the mid-run reset.
    run(mk(2, "p_pre1", 1, 1, 0, 0, 0, 0, 0, 0, 0));
    run(mk(2, "p_pre2", 1, 1, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-cycle at cnt=42, checked before the next edge.
    idle_all();
    en_v[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst.cnt", 32'(cnt_v[0]), 32'd0);
    chk("arst.ovf", 32'(ovf_v[0]), 32'd0);
    chk("arst.tc",  32'(tc_v[0]),  32'd0);
    en_v[0] = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst.hold", 32'(cnt_v[0]), 32'd0);

    // sel 0: wrap, M=100
    tbl.push_back(mk(0, "ld2",       0, 0, 0, 1,   2, 0, 0,  2, 0));
    tbl.push_back(mk(0, "dn1",       1, 0, 0, 0,   0, 0, 0,  1, 0));
    tbl.push_back(mk(0, "dn0",       1, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(0, "dnwrap",    1, 0, 0, 0,   0, 0, 1, 99, 1));
    tbl.push_back(mk(0, "dirup",     1, 1, 0, 0,   0, 0, 1,  0, 1));
    tbl.push_back(mk(0, "en_off",    0, 1, 0, 0,   0, 0, 0,  0, 1));
    tbl.push_back(mk(0, "prio",      1, 1, 1, 1,  50, 0, 0,  0, 0));
    tbl.push_back(mk(0, "ld99",      0, 0, 0, 1,  99, 0, 0, 99, 0));
    tbl.push_back(mk(0, "ovf_race",  1, 1, 0, 0,   0, 1, 1,  0, 1));
    tbl.push_back(mk(0, "ovf_clr",   0, 0, 0, 0,   0, 1, 0,  0, 0));
    tbl.push_back(mk(0, "ld120",     0, 0, 0, 1, 120, 0, 0, 99, 0));
    tbl.push_back(mk(0, "ld_tick",   1, 1, 0, 1,   5, 0, 0,  5, 0));
    tbl.push_back(mk(0, "ld100",     0, 0, 0, 1, 100, 0, 0, 99, 0));
    tbl.push_back(mk(0, "clr_tick",  1, 1, 1, 0,   0, 0, 0,  0, 0));
    // sel 1: saturate, M=100
    tbl.push_back(mk(1, "s_dn0",     1, 0, 0, 0,   0, 0, 1,  0, 1));
    tbl.push_back(mk(1, "s_oc",      0, 0, 0, 0,   0, 1, 0,  0, 0));
    tbl.push_back(mk(1, "s_ld120",   0, 0, 0, 1, 120, 0, 0, 99, 0));
    tbl.push_back(mk(1, "s_up99",    1, 1, 0, 0,   0, 0, 1, 99, 1));
    tbl.push_back(mk(1, "s_dn98",    1, 0, 0, 0,   0, 0, 0, 98, 1));
    tbl.push_back(mk(1, "s_up",      1, 1, 0, 0,   0, 0, 0, 99, 1));
    tbl.push_back(mk(1, "s_clr",     0, 0, 1, 0,   0, 0, 0,  0, 0));
    // sel 2: prescale 4; en 1,1,0,1,1 -> first step on the 4th enabled cycle
    tbl.push_back(mk(2, "p_e1",      1, 1, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_e2",      1, 1, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_off",     0, 1, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_e3",      1, 1, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_e4",      1, 1, 0, 0,   0, 0, 0,  1, 0));
    tbl.push_back(mk(2, "p_e5",      1, 1, 0, 0,   0, 0, 0,  1, 0));
    tbl.push_back(mk(2, "p_e6",      1, 1, 0, 0,   0, 0, 0,  1, 0));
    tbl.push_back(mk(2, "p_ld10",    1, 1, 0, 1,  10, 0, 0, 10, 0));
    tbl.push_back(mk(2, "p_f1",      1, 1, 0, 0,   0, 0, 0, 10, 0));
    tbl.push_back(mk(2, "p_f2",      1, 1, 0, 0,   0, 0, 0, 10, 0));
    tbl.push_back(mk(2, "p_f3",      1, 1, 0, 0,   0, 0, 0, 10, 0));
    tbl.push_back(mk(2, "p_f4",      1, 1, 0, 0,   0, 0, 0, 11, 0));
    tbl.push_back(mk(2, "p_ld0",     0, 0, 0, 1,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_d1",      1, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_d2",      1, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_d3",      1, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(2, "p_dwrap",   1, 0, 0, 0,   0, 0, 1, 99, 1));
    // sel 3: MODULUS == 2**DWIDTH (3 bits, 0..7)
    tbl.push_back(mk(3, "b_ld7",     0, 0, 0, 1,   7, 0, 0,  7, 0));
    tbl.push_back(mk(3, "b_upwrap",  1, 1, 0, 0,   0, 0, 1,  0, 1));
    tbl.push_back(mk(3, "b_dnwrap",  1, 0, 0, 0,   0, 0, 1,  7, 1));
    tbl.push_back(mk(3, "b_dn6",     1, 0, 0, 0,   0, 0, 0,  6, 1));
    tbl.push_back(mk(3, "b_up7",     1, 1, 0, 0,   0, 0, 0,  7, 1));
    tbl.push_back(mk(3, "b_clr",     0, 0, 1, 0,   0, 0, 0,  0, 0));

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i]);

    if (exp_q.size() != 0)
      chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised modulo-N up/down counter with enable prescaler, synchronous clear/load, wrap or saturate mode, cascade carry and sticky overflow flag. Successor to the plain free-running enable counter. Used for event/cycle counting, timebase generation and cascaded wide counters. Counter value wraps at a programmable modulus, not only at 2^DWIDTH.

Parameters:
DWIDTH, 7, counter width in bits
MODULUS, 100, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**DWIDTH
PRESCALE, 1, enabled cycles per count step; legal >= 1 (1 = step every enabled cycle)
SATURATE, 0, 0 = wrap at boundary; 1 = hold at boundary

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  count enable, qualifies prescaler advance
up_dn  in  1  1 = count up, 0 = count down; sampled on each step
clr  in  1  synchronous clear of counter, prescaler and overflow flag
load  in  1  synchronous load of load_val
load_val  in  DWIDTH  load value
ovf_clr  in  1  synchronous clear of ovf_o only
cnt_o  out  DWIDTH  registered counter value
tc_o  out  1  combinational terminal-count/carry: step occurs this cycle at boundary
ovf_o  out  1  registered sticky flag: a boundary step has occurred

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: cnt_o = 0, prescaler = 0, ovf_o = 0, immediately on rst assertion, independent of clk. tc_o = 0 while rst is high.
- Priority per cycle: clr > load > step. ovf_clr is independent of load/step. clr also clears ovf_o.
- clr: next cnt_o = 0, prescaler = 0, ovf_o = 0; no step, tc_o = 0.
- load: next cnt_o = load_val if load_val < MODULUS, else MODULUS-1 (clamp). Prescaler reset to 0; no step, tc_o = 0.
- Prescaler: internal counter 0..PRESCALE-1 advancing on en. tick = en & (presc == PRESCALE-1). On tick the prescaler returns to 0. When PRESCALE = 1, tick = en and no prescaler register exists. en low freezes the prescaler.
- Step, on tick with no clr/load:
  - up, cnt < MODULUS-1: cnt+1.
  - down, cnt > 0: cnt-1.
  - up at MODULUS-1: next value is 0 (SATURATE=0) or MODULUS-1 held (SATURATE=1).
  - down at 0: next value is MODULUS-1 (SATURATE=0) or 0 held (SATURATE=1).
- tc_o = tick & ~clr & ~load & boundary, where boundary = (up_dn ? cnt==MODULUS-1 : cnt==0). tc_o asserts in the same cycle as the wrapping step, in both modes. tc_o drives the en of the next cascade stage.
- ovf_o: set on the clock edge where tc_o = 1. Cleared by clr or ovf_clr. If ovf_clr and tc_o are both high in the same cycle, set wins (event not lost).
- up_dn may change on any cycle. Direction takes effect on the next tick only, with no extra latency.
- Arithmetic: internal compare and increment use DWIDTH bits; the MODULUS-1 constant must be sized to DWIDTH. When MODULUS == 2**DWIDTH the natural binary wrap must equal the modulo wrap.
- Latency: cnt_o updates on the edge following tick; tc_o is zero-latency combinational.
- rst mid-count: all state clears asynchronously. The first tick after release needs a full PRESCALE enabled cycles.

Decomposition:
- Shared counter package: mode constants (MODE_WRAP = 0, MODE_SAT = 1) and a clog2 helper for prescaler width (max(1, clog2(PRESCALE))).
- One sub-module: tick_prescaler (clk, rst, en, sync_clr, tick_o), parameter PRESCALE, bypassed by generate when PRESCALE = 1.
- Top holds the counter register, boundary/carry logic and overflow flag.

Test Plan:
- Reset/prescale: DWIDTH=7, MODULUS=100, PRESCALE=1, SATURATE=0; assert rst mid-count at cnt=42 -> cnt_o=0 and ovf_o=0 asynchronously, before next clk edge.
- Up wrap: en=1, up_dn=1, count from 0 -> cnt_o reaches 99 after 99 cycles; tc_o=1 exactly in that cycle; next cnt_o=0, ovf_o=1.
- Down wrap and direction change: load 2, then down -> 1, 0, 99 with tc_o on the 0->99 step; switch up_dn=1 at 99 -> 0 with tc_o=1.
- Saturate: SATURATE=1, load_val=120 -> cnt_o=99 (clamp); up step -> stays 99, tc_o=1, ovf_o=1. Down from 0 -> stays 0.
- Prescaler: PRESCALE=4, en toggled 1,1,0,1,1 -> first step after the 4th enabled cycle (cnt_o=1). load mid-prescale resets the phase; the next step needs 4 more enabled cycles.
- Priority and ovf race: clr+load+tick in the same cycle -> cnt_o=0, tc_o=0. ovf_clr with a tc_o event in the same cycle -> ovf_o stays 1. ovf_clr alone -> ovf_o=0.
